// File: rtl/rs232_xmt393_if.sv
// rtl/rs232_xmt393_if.sv - byte write port and FIFO status of the serial transmitter
interface rs232_xmt393_if #(
    parameter int FIFO_DEPTH_LOG2 = 2
) ();
    logic [7:0]               din;
    logic                     din_stb;
    logic                     fifo_full;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     overflow;

    modport master (
        output din, din_stb,
        input  fifo_full, fifo_count, overflow
    );

    modport slave (
        input  din, din_stb,
        output fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/rs232_xmt393.sv
// rtl/rs232_xmt393.sv - FIFO-buffered RS232 transmitter, 8 data bits, optional parity, 1/2 stop bits
module rs232_xmt393 #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic          xclk,
    input  logic          rst,
    input  logic [15:0]   bitHalfPeriod,
    input  logic          stop2,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          ser_rst,
    rs232_xmt393_if.slave wr,
    output logic          ser_do,
    output logic          busy,
    output logic          char_done
);
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              count_q, count_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]                 mem_q [DEPTH];
    logic [7:0]                 shift_q, shift_d;
    logic                       par_q, par_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic                       half_q, half_d;
    logic [15:0]                timer_q, timer_d;
    logic [15:0]                hbp_q, hbp_d;
    logic                       stop2_q, stop2_d;
    logic                       par_en_q, par_en_d;
    logic                       par_odd_q, par_odd_d;
    logic                       overflow_q, overflow_d;
    logic                       ser_do_q, ser_do_d;
    logic                       char_done_q, char_done_d;
    logic                       full, push, pop, load, bit_end;
    logic [15:0]                hbp_load;

    assign full     = (count_q == DEPTH_CNT);
    // A zero half period would never expire, so it is stretched to one cycle.
    assign hbp_load = (bitHalfPeriod == 16'd0) ? 16'd1 : bitHalfPeriod;

    assign wr.fifo_full  = full;
    assign wr.fifo_count = count_q;
    assign wr.overflow   = overflow_q;
    assign ser_do        = ser_do_q;
    assign char_done     = char_done_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);

    // Next-state logic: FIFO bookkeeping, half-bit timer, framing FSM and output bit selection.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        half_d      = half_q;
        timer_d     = timer_q;
        hbp_d       = hbp_q;
        stop2_d     = stop2_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        overflow_d  = overflow_q;
        char_done_d = 1'b0;
        load        = 1'b0;
        bit_end     = 1'b0;

        // Fullness is judged on current occupancy, so a same-cycle pop never rescues a write.
        push = wr.din_stb && !full;
        if (wr.din_stb && full) begin
            overflow_d = 1'b1;
        end

        // Each bit is two half periods; bit_end marks the last cycle of the second half.
        if (state_q != IDLE) begin
            if (timer_q <= 16'd1) begin
                timer_d = hbp_q;
                half_d  = ~half_q;
                bit_end = half_q;
            end else begin
                timer_d = timer_q - 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = 3'd0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_cnt_q == 3'd0)) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        char_done_d = 1'b1;
                        if (count_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a byte also snapshots the line configuration for the whole character.
        pop = load;
        if (load) begin
            state_d   = START;
            shift_d   = mem_q[rd_ptr_q];
            par_d     = ^mem_q[rd_ptr_q];
            bit_cnt_d = 3'd0;
            half_d    = 1'b0;
            hbp_d     = hbp_load;
            timer_d   = hbp_load;
            stop2_d   = stop2;
            par_en_d  = parity_en;
            par_odd_d = parity_odd;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // The line lags the FSM by one cycle so that ser_do is purely a flop.
        case (state_q)
            START:   ser_do_d = 1'b0;
            DATA:    ser_do_d = shift_q[0];
            PARITY:  ser_do_d = par_q ^ par_odd_q;
            default: ser_do_d = 1'b1;
        endcase

        if (ser_rst) begin
            state_d     = IDLE;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            ser_do_d    = 1'b1;
            char_done_d = 1'b0;
            push        = 1'b0;
        end
    end

    // Byte storage; contents need no reset because occupancy is tracked by count_q.
    always_ff @(posedge xclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr.din;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            bit_cnt_q   <= 3'd0;
            half_q      <= 1'b0;
            timer_q     <= 16'd1;
            hbp_q       <= 16'd1;
            stop2_q     <= 1'b0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            overflow_q  <= 1'b0;
            ser_do_q    <= 1'b1;
            char_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            half_q      <= half_d;
            timer_q     <= timer_d;
            hbp_q       <= hbp_d;
            stop2_q     <= stop2_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            overflow_q  <= overflow_d;
            ser_do_q    <= ser_do_d;
            char_done_q <= char_done_d;
        end
    end
endmodule

// File: tb/tb_rs232_xmt393.sv
// tb/tb_rs232_xmt393.sv - self-checking bench for rs232_xmt393 using a recorded-trace line model
module tb_rs232_xmt393;
    logic        xclk = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] bitHalfPeriod = 16'd4;
    logic        stop2 = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, ser_rst = 1'b0;
    logic        ser_do, busy, char_done;

    int checks = 0;
    int errors = 0;

    rs232_xmt393_if #(.FIFO_DEPTH_LOG2(2)) wr_if ();

    rs232_xmt393 #(.FIFO_DEPTH_LOG2(2)) dut (
        .xclk          (xclk),
        .rst           (rst),
        .bitHalfPeriod (bitHalfPeriod),
        .stop2         (stop2),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .ser_rst       (ser_rst),
        .wr            (wr_if.slave),
        .ser_do        (ser_do),
        .busy          (busy),
        .char_done     (char_done)
    );

    always #5 xclk = ~xclk;

    // Line trace sampled once per cycle while rec is set.
    bit rec = 1'b0;
    bit tr_do[$];
    bit tr_cd[$];
    always @(negedge xclk) begin
        if (rec) begin
            tr_do.push_back(ser_do);
            tr_cd.push_back(char_done);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_bytes(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(negedge xclk);
            wr_if.din     = b[i];
            wr_if.din_stb = 1'b1;
        end
        @(negedge xclk);
        wr_if.din_stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 6000) begin
            @(negedge xclk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 6000), 32'd1);
        repeat (3) @(negedge xclk);
    endtask

    // Reference line: frames back to back from the first low sample, each bit held 2*max(H,1)
    // cycles, char_done on the final cycle of each frame, idle high everywhere else.
    task automatic analyze(input string tag, input logic [7:0] b[$], input int h,
                           input bit s2, input bit pe, input bit po);
        int hh = (h == 0) ? 1 : h;
        int s  = -1;
        int bad = 0;
        bit exp_do[$];
        bit exp_cd[$];
        foreach (b[k]) begin
            bit bits[$];
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(b[k][i]);
            if (pe) bits.push_back(po ? ($countones(b[k]) % 2 == 0) : ($countones(b[k]) % 2 == 1));
            bits.push_back(1'b1);
            if (s2) bits.push_back(1'b1);
            foreach (bits[j]) begin
                for (int c = 0; c < 2 * hh; c++) begin
                    exp_do.push_back(bits[j]);
                    exp_cd.push_back(1'b0);
                end
            end
            exp_cd[exp_cd.size() - 1] = 1'b1;
        end
        foreach (tr_do[i]) begin
            if (s < 0 && tr_do[i] == 1'b0) s = i;
        end
        if (s < 0) begin
            bad = 1;
        end else begin
            for (int i = 0; i < s; i++) if (tr_do[i] != 1'b1 || tr_cd[i] != 1'b0) bad++;
            foreach (exp_do[i]) begin
                if (s + i >= tr_do.size()) bad++;
                else if (tr_do[s + i] != exp_do[i] || tr_cd[s + i] != exp_cd[i]) bad++;
            end
            for (int i = s + exp_do.size(); i < tr_do.size(); i++)
                if (tr_do[i] != 1'b1 || tr_cd[i] != 1'b0) bad++;
        end
        check({tag, "_line_bad_cycles"}, 32'(bad), 32'd0);
    endtask

    task automatic start_rec();
        tr_do.delete();
        tr_cd.delete();
        rec = 1'b1;
    endtask

    initial begin
        logic [7:0] q[$];
        int n;
        bit full_seen;
        bit bad_flag;

        wr_if.din = 8'd0;
        wr_if.din_stb = 1'b0;
        repeat (3) @(negedge xclk);
        check("rst_ser_do", 32'(ser_do), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(wr_if.fifo_full), 32'd0);
        check("rst_count", 32'(wr_if.fifo_count), 32'd0);
        check("rst_char_done", 32'(char_done), 32'd0);
        check("rst_overflow", 32'(wr_if.overflow), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge xclk);

        // 1: 8N1, H=4, 0x55 with write-to-line latency
        start_rec();
        @(negedge xclk);
        wr_if.din = 8'h55;
        wr_if.din_stb = 1'b1;
        @(negedge xclk);
        wr_if.din_stb = 1'b0;
        check("t1_busy_rise", 32'(busy), 32'd1);
        check("t1_count_1", 32'(wr_if.fifo_count), 32'd1);
        check("t1_do_idle_n", 32'(ser_do), 32'd1);
        @(negedge xclk);
        check("t1_count_popped", 32'(wr_if.fifo_count), 32'd0);
        check("t1_do_idle_n1", 32'(ser_do), 32'd1);
        @(negedge xclk);
        check("t1_do_start_n2", 32'(ser_do), 32'd0);
        wait_idle("t1");
        rec = 1'b0;
        analyze("t1", '{8'h55}, 4, 0, 0, 0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: parity even / odd, then two stop bits
        parity_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            parity_odd = (k == 1);
            stop2      = (k == 2);
            start_rec();
            write_bytes('{8'h07});
            wait_idle("t2");
            rec = 1'b0;
            analyze($sformatf("t2_%0d", k), '{8'h07}, 4, k == 2, 1, k == 1);
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;
        stop2 = 1'b0;

        // 3: three contiguous frames at H=3
        bitHalfPeriod = 16'd3;
        q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        start_rec();
        write_bytes(q);
        wait_idle("t3");
        rec = 1'b0;
        analyze("t3", q, 3, 0, 0, 0);

        // 4: six writes on consecutive cycles into a four-entry FIFO
        bitHalfPeriod = 16'd1;
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        full_seen = 1'b0;
        start_rec();
        foreach (q[i]) begin
            @(negedge xclk);
            if (wr_if.fifo_full === 1'b1) full_seen = 1'b1;
            wr_if.din = q[i];
            wr_if.din_stb = 1'b1;
        end
        @(negedge xclk);
        wr_if.din_stb = 1'b0;
        if (wr_if.fifo_full === 1'b1) full_seen = 1'b1;
        check("t4_full_seen", 32'(full_seen), 32'd1);
        check("t4_overflow", 32'(wr_if.overflow), 32'd1);
        wait_idle("t4");
        rec = 1'b0;
        q.pop_back();
        analyze("t4", q, 1, 0, 0, 0);
        check("t4_overflow_sticky", 32'(wr_if.overflow), 32'd1);

        // 5: soft reset during data bit 3 with two bytes queued
        bitHalfPeriod = 16'd2;
        write_bytes('{8'h00, 8'hA5, 8'h5A});
        n = 0;
        while (ser_do !== 1'b0 && n < 50) begin
            @(negedge xclk);
            n++;
        end
        check("t5_start_seen", 32'(n < 50), 32'd1);
        repeat (17) @(negedge xclk);
        check("t5_queued", 32'(wr_if.fifo_count), 32'd2);
        ser_rst = 1'b1;
        wr_if.din = 8'hFF;
        wr_if.din_stb = 1'b1;
        @(negedge xclk);
        ser_rst = 1'b0;
        wr_if.din_stb = 1'b0;
        check("t5_do", 32'(ser_do), 32'd1);
        check("t5_count", 32'(wr_if.fifo_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_char_done", 32'(char_done), 32'd0);
        check("t5_overflow_clr", 32'(wr_if.overflow), 32'd0);
        bad_flag = 1'b0;
        repeat (60) begin
            @(negedge xclk);
            if (char_done !== 1'b0 || ser_do !== 1'b1 || busy !== 1'b0) bad_flag = 1'b1;
        end
        check("t5_quiet_after", 32'(bad_flag), 32'd0);

        // 6: zero half period, then asynchronous reset mid-frame
        bitHalfPeriod = 16'd0;
        q = '{8'($urandom)};
        start_rec();
        write_bytes(q);
        wait_idle("t6");
        rec = 1'b0;
        analyze("t6", q, 0, 0, 0, 0);
        write_bytes('{8'h00, 8'h00});
        repeat (6) @(negedge xclk);
        check("t6_pre_rst_do", 32'(ser_do), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_async_do", 32'(ser_do), 32'd1);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_count", 32'(wr_if.fifo_count), 32'd0);
        check("t6_async_cd", 32'(char_done), 32'd0);
        @(negedge xclk);
        rst = 1'b0;
        repeat (2) @(negedge xclk);

        // Randomized frames; single-byte cases scramble the configuration mid-frame.
        for (int it = 0; it < 8; it++) begin
            int h;
            bit s2, pe, po;
            int nb;
            h  = $urandom_range(0, 5);
            s2 = 1'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            nb = $urandom_range(1, 3);
            bitHalfPeriod = 16'(h);
            stop2 = s2;
            parity_en = pe;
            parity_odd = po;
            q.delete();
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            start_rec();
            write_bytes(q);
            if (nb == 1) begin
                repeat (2) @(negedge xclk);
                bitHalfPeriod = 16'($urandom_range(6, 9));
                stop2 = ~s2;
                parity_en = ~pe;
                parity_odd = ~po;
            end
            wait_idle($sformatf("rnd%0d", it));
            rec = 1'b0;
            analyze($sformatf("rnd%0d", it), q, h, s2, pe, po);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
